// File: rtl/dreg_mux_pkg.sv
// Shared constants and operand-select encodings for the dreg_mux register/operand block.
package dreg_mux_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } addsub_e;

endpackage

// File: rtl/dreg_bit.sv
// Single flip-flop with load enable and asynchronous active-low clear.
// Latency: one clock from d to q when en is high; clear acts immediately.
// Backpressure: none; en high loads on every edge, en low holds.
module dreg_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dreg_mux.sv
// Loadable register feeding an adder operand (true/complement + carry-in) and an enable-gated bus; DREG_MUX_TRISTATE_EN floats Bus when disabled.
// Latency: one clock D->Q; Qn, Y, Cin and Bus follow Q and the selects combinationally.
// Backpressure: none; Latch high captures D on every rising MainClock edge.
module dreg_mux
    import dreg_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             MainClock,
    input  logic             MainReset,
    input  logic             Latch,
    input  logic [WIDTH-1:0] D,
    input  logic             AddSub,
    input  logic             Enable,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] Y,
    output logic             Cin,
    output logic [WIDTH-1:0] Bus
);

    logic sub_sel;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dreg_bit u_bit (
            .clk   (MainClock),
            .rst_n (MainReset),
            .en    (Latch),
            .d     (D[i]),
            .q     (Q[i])
        );
    end

    assign sub_sel = (addsub_e'(AddSub) == SUB);

    // Complemented operand plus carry-in of one gives the two's complement negation of Q.
    assign Qn  = ~Q;
    assign Y   = sub_sel ? ~Q : Q;
    assign Cin = sub_sel;

`ifdef DREG_MUX_TRISTATE_EN
    assign Bus = Enable ? Q : {WIDTH{1'bz}};
`else
    assign Bus = Enable ? Q : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_dreg_mux.sv
// Self-checking bench for dreg_mux: directed scenarios plus randomized traffic against a behavioural model.
module tb_dreg_mux;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         latch;
    logic [W-1:0] d;
    logic         addsub;
    logic         enable;
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic [W-1:0] y;
    logic         cin;
    logic [W-1:0] bus;

    int passed;
    int total;

    dreg_mux #(.WIDTH(W)) dut (
        .MainClock (clk),
        .MainReset (rst_n),
        .Latch     (latch),
        .D         (d),
        .AddSub    (addsub),
        .Enable    (enable),
        .Q         (q),
        .Qn        (qn),
        .Y         (y),
        .Cin       (cin),
        .Bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] bus_ref(input logic en, input logic [W-1:0] v);
`ifdef DREG_MUX_TRISTATE_EN
        return en ? v : {W{1'bz}};
`else
        return en ? v : {W{1'b0}};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        @(negedge clk);
        d     = v;
        latch = 1'b1;
        tick();
        latch = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        d      = 4'b1010;
        latch  = 1'b1;
        addsub = 1'b0;
        tick();
        tick();
        total++;
        if (q !== 4'b0000) $display("FAIL reset_q: got %b want 0000", q);
        else passed++;
        total++;
        if (qn !== 4'b1111) $display("FAIL reset_qn: got %b want 1111", qn);
        else passed++;
        total++;
        if ({y, cin} !== 5'b0000_0) $display("FAIL reset_add_y_cin: got %b/%b want 0000/0", y, cin);
        else passed++;
        addsub = 1'b1;
        #1;
        total++;
        if ({y, cin} !== 5'b1111_1) $display("FAIL reset_sub_y_cin: got %b/%b want 1111/1", y, cin);
        else passed++;
        @(negedge clk);
        rst_n  = 1'b1;
        latch  = 1'b0;
        addsub = 1'b0;
    endtask

    task automatic test_load();
        load(4'b0110);
        total++;
        if (q !== 4'b0110) $display("FAIL load_q: got %b want 0110", q);
        else passed++;
        @(negedge clk);
        d = 4'b1111;
        tick();
        // D glitches between edges must not reach Q.
        @(negedge clk);
        d = 4'b0001;
        #2;
        d = 4'b1000;
        #1;
        total++;
        if (q !== 4'b0110) $display("FAIL hold_q: got %b want 0110", q);
        else passed++;
        tick();
        total++;
        if (q !== 4'b0110) $display("FAIL hold_after_edge_q: got %b want 0110", q);
        else passed++;
    endtask

    task automatic test_addsub();
        @(negedge clk);
        addsub = 1'b0;
        #1;
        total++;
        if ({y, cin} !== 5'b0110_0) $display("FAIL add_y_cin: got %b/%b want 0110/0", y, cin);
        else passed++;
        addsub = 1'b1;
        #1;
        total++;
        if ({y, cin} !== 5'b1001_1) $display("FAIL sub_y_cin: got %b/%b want 1001/1", y, cin);
        else passed++;
        total++;
        if (q !== 4'b0110) $display("FAIL addsub_keeps_q: got %b want 0110", q);
        else passed++;
        addsub = 1'b0;
    endtask

    task automatic test_bus();
        load(4'b0011);
        @(negedge clk);
        enable = 1'b1;
        #1;
        total++;
        if (bus !== 4'b0011) $display("FAIL bus_enabled: got %b want 0011", bus);
        else passed++;
        enable = 1'b0;
        #1;
        total++;
        if (bus !== bus_ref(1'b0, 4'b0011)) $display("FAIL bus_disabled: got %b want %b", bus, bus_ref(1'b0, 4'b0011));
        else passed++;
        total++;
        if (q !== 4'b0011) $display("FAIL enable_keeps_q: got %b want 0011", q);
        else passed++;
    endtask

    task automatic test_subtract();
        logic [W-1:0] sum;
        load(4'b0011);
        @(negedge clk);
        addsub = 1'b1;
        #1;
        sum = 4'b0111 + y + {{(W-1){1'b0}}, cin};
        total++;
        if (sum !== 4'b0100) $display("FAIL subtract_7_minus_3: got %b want 0100", sum);
        else passed++;
        addsub = 1'b0;
    endtask

    task automatic test_async_reset();
        load(4'b1100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (q !== 4'b0000) $display("FAIL async_clear_q: got %b want 0000", q);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        d     = 4'b0101;
        latch = 1'b1;
        tick();
        latch = 1'b0;
        total++;
        if (q !== 4'b0101) $display("FAIL post_reset_load_q: got %b want 0101", q);
        else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] mq;
        logic [W-1:0] ey;
        mq = q;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            d      = W'($urandom);
            latch  = 1'($urandom);
            addsub = 1'($urandom);
            enable = 1'($urandom);
            rst_n  = ($urandom_range(0, 15) != 0);
            if (!rst_n) mq = '0;
            #1;
            ey = addsub ? (~mq) : mq;
            total++;
            if ({q, qn, y, cin} !== {mq, ~mq, ey, addsub})
                $display("FAIL rand_comb[%0d]: got q=%b qn=%b y=%b cin=%b want q=%b y=%b cin=%b",
                         n, q, qn, y, cin, mq, ey, addsub);
            else passed++;
            total++;
            if (bus !== bus_ref(enable, mq)) $display("FAIL rand_bus[%0d]: got %b want %b", n, bus, bus_ref(enable, mq));
            else passed++;
            tick();
            if (rst_n && latch) mq = d;
            total++;
            if (q !== mq) $display("FAIL rand_edge_q[%0d]: got %b want %b", n, q, mq);
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        latch = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b1;
        latch  = 1'b0;
        d      = '0;
        addsub = 1'b0;
        enable = 1'b0;
        test_reset();
        test_load();
        test_addsub();
        test_bus();
        test_subtract();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
